stopwatch_controller: RTL and testbench
=======================================

STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

Interface
REQ-001 Parameter BOARD_CLOCK_FREQUENCY_IN_HZ, default 100_000_000: input clock frequency.
REQ-002 Parameter TICK_RATE_IN_HZ, default 100: count resolution; one tick = 0.01 s.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1_000_000: stable cycles required before a button level is accepted.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 btn_start  input  1  raw start/stop button, asynchronous to clk.
REQ-007 btn_lap  input  1  raw lap button, asynchronous to clk.
REQ-008 btn_clear  input  1  raw clear button, asynchronous to clk.
REQ-009 number  output  16  BCD display value {d3,d2,d1,d0}: d3 = tens of seconds, d2 = seconds, d1 = tenths, d0 = hundredths; feeds the display driver.
REQ-010 an  output  4  per-digit enable for the display driver.
REQ-011 running  output  1  high in RUN and LAP.
REQ-012 overflow  output  1  one-cycle pulse on wrap from 99.99 to 00.00.
REQ-013 state  output  2  current FSM state encoding.

Function
REQ-014 Each button path: 2-flop synchronizer, then debounce. The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-015 Each button produces a one-cycle event pulse on a debounced 0->1 transition. There is no event on release.
REQ-016 FSM states: IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-017 Transitions:
- IDLE: start -> RUN.
- RUN: start -> PAUSE; lap -> LAP.
- PAUSE: start -> RUN; clear -> IDLE.
- LAP: start -> PAUSE; lap -> RUN.
- All other events are ignored, including clear in IDLE, RUN and LAP.
REQ-018 Simultaneous events in the same cycle: only the highest-priority legal event acts. Priority: clear > start > lap.
REQ-019 Tick divider:
- Counts 0 to (BOARD_CLOCK_FREQUENCY_IN_HZ/TICK_RATE_IN_HZ)-1 only in RUN and LAP.
- Holds its value in PAUSE, so resume preserves the sub-tick phase.
- Forced to 0 in IDLE.
REQ-020 Tick pulse: asserted for one cycle when the divider wraps to 0.
REQ-021 Live count: four cascaded BCD digits, each 0-9. A tick increments d0; a carry propagates on 9->0. Every digit updates in the same cycle.
REQ-022 At 99.99 a tick wraps the live count to 00.00 and asserts overflow in the same cycle as the wrap.
REQ-023 Clear event accepted in PAUSE: the live count and divider are 0 on the next cycle.
REQ-024 number is registered:
- It equals the live count one cycle after each live-count update, except in LAP.
- On the transition into LAP it captures the live count and then holds that value while the live count continues.
- On leaving LAP it resumes tracking the live count with one-cycle latency.
REQ-025 an[2:0] = 3'b111 always. an[3] = 0 when displayed d3 == 0 (leading-zero blank), else 1.
REQ-026 Digit values 10-15 are never produced.

Reset
REQ-027 While rst is asserted:
- state = IDLE;
- number = 16'h0000, an = 4'b0111, running = 0, overflow = 0;
- divider, live count, synchronizers, debounce counters and debounced levels are all 0.
REQ-028 Reset mid-operation (any state) aborts immediately, with no event pulse generated on release of reset. Buttons held through reset release register as pressed only after a full debounce interval.

Structure
REQ-029 The state encodings, digit count (4) and BCD width (4) are defined in the shared package stopwatch_pkg.
REQ-030 Debounce and edge detection are implemented as sub-module button_conditioner (parameter DEBOUNCE_CYCLES), instantiated three times.
REQ-031 The FSM, divider and BCD counter live in stopwatch_controller. No clock is derived from logic; the tick is an enable.

Verification
REQ-032 All scenarios use BOARD_CLOCK_FREQUENCY_IN_HZ=1000, TICK_RATE_IN_HZ=100 and DEBOUNCE_CYCLES=4 (10 cycles per tick).
REQ-033 Bench scenarios:
- Reset, then no buttons -> number=0000, an=0111, state=0 indefinitely.
- Start press held 10 cycles, then 250 cycles -> state=1; number=0025 within +/-1 tick.
- RUN, lap at count 0012, wait 100 cycles -> number stays 0012 while live count reaches 0022; second lap -> number=0022 next cycle.
- Live count preset to 9999 via run, next tick -> number=0000 and a one-cycle overflow pulse.
- PAUSE at 0345, clear and start asserted in the same cycle -> state=0 and number=0000; clear during RUN -> ignored.
- Start press bouncing with 2-cycle glitches -> no event; rst pulsed during RUN -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: FSM state encoding, digit geometry
// and the cascaded BCD increment used by the live counter.
package stopwatch_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4;
    localparam int COUNT_W    = NUM_DIGITS * BCD_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_e;

    // Adds one to a packed BCD value. The top bit of the result is the carry
    // out of the most significant digit, i.e. the 99.99 -> 00.00 wrap.
    function automatic logic [COUNT_W:0] bcd_increment(input logic [COUNT_W-1:0] value);
        logic [COUNT_W-1:0] result;
        logic               carry;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (value[i*BCD_W +: BCD_W] == BCD_W'(9)) begin
                    result[i*BCD_W +: BCD_W] = '0;
                end else begin
                    result[i*BCD_W +: BCD_W] = value[i*BCD_W +: BCD_W] + BCD_W'(1);
                    carry = 1'b0;
                end
            end
        end
        return {carry, result};
    endfunction

endpackage

// File: rtl/stopwatch_button_conditioner.sv
// Conditions one raw push button: two-flop synchronizer, a debounce counter
// that accepts a new level only after it has been stable for DEBOUNCE_CYCLES
// consecutive cycles, and a one-cycle press pulse on an accepted 0->1 change.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    // Count consecutive cycles where the synchronized input disagrees with the
    // accepted level; any agreement restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                press_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchronizer and debounce state; everything clears on reset so a button
    // held through reset is seen as a fresh press after a full interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch top: three conditioned buttons drive a four-state FSM, a tick
// divider used as an enable, a four-digit BCD live counter and a registered
// display value that freezes while a lap is shown.
// Handshake note: button events are single-cycle pulses with no back-pressure;
// an event not legal in the current state is simply dropped.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int TICK_RATE_IN_HZ             = 100,
    parameter int DEBOUNCE_CYCLES             = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [15:0] number,
    output logic [3:0]  an,
    output logic        running,
    output logic        overflow,
    output logic [1:0]  state
);

    localparam int DIV   = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_RATE_IN_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic ev_start, ev_lap, ev_clear;

    sw_state_e          state_q;
    logic               running_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] number_q, number_d;
    logic               overflow_q, overflow_d;
    logic [COUNT_W:0]   count_inc;
    logic               is_running, tick, clear_accept, lap_hold;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_cond (
        .clk(clk), .rst(rst), .btn_i(btn_start), .press_o(ev_start)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap_cond (
        .clk(clk), .rst(rst), .btn_i(btn_lap), .press_o(ev_lap)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_cond (
        .clk(clk), .rst(rst), .btn_i(btn_clear), .press_o(ev_clear)
    );

    // Divider, live count and display next-state. The display holds only while
    // the FSM stays in LAP; entering LAP captures, leaving LAP tracks again.
    always_comb begin
        is_running   = (state_q == ST_RUN) || (state_q == ST_LAP);
        tick         = is_running && (div_q == DIV_LAST);
        clear_accept = (state_q == ST_PAUSE) && ev_clear;
        lap_hold     = (state_q == ST_LAP) && !ev_start && !ev_lap;
        count_inc    = bcd_increment(count_q);
        div_d        = div_q;
        count_d      = count_q;
        overflow_d   = 1'b0;
        if ((state_q == ST_IDLE) || clear_accept) begin
            div_d   = '0;
            count_d = '0;
        end else if (is_running) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                count_d    = count_inc[COUNT_W-1:0];
                overflow_d = count_inc[COUNT_W];
            end
        end
        number_d = lap_hold ? number_q : count_q;
    end

    // Datapath registers: divider phase, live BCD count, display, wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            count_q    <= '0;
            number_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            count_q    <= count_d;
            number_q   <= number_d;
            overflow_q <= overflow_d;
        end
    end

    // Control FSM; each branch tests events in clear > start > lap order and
    // only the events legal in that state, so the first match is the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ev_start) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ev_start) begin
                        state_q   <= ST_PAUSE;
                        running_q <= 1'b0;
                    end else if (ev_lap) begin
                        state_q   <= ST_LAP;
                        running_q <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (ev_clear) begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end else if (ev_start) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_LAP: begin
                    if (ev_start) begin
                        state_q   <= ST_PAUSE;
                        running_q <= 1'b0;
                    end else if (ev_lap) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign number   = number_q;
    assign an       = {(number_q[COUNT_W-1 -: BCD_W] != BCD_W'(0)), 3'b111};
    assign running  = running_q;
    assign overflow = overflow_q;
    assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: directed sequences, a table of button
// vectors and random presses, all compared against a cycle-level model that
// derives the count arithmetically from the number of running cycles.
module tb_stopwatch_controller;

    localparam int F_HZ  = 1000;
    localparam int T_HZ  = 100;
    localparam int DC    = 4;
    localparam int DIV_M = F_HZ / T_HZ;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_start = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
    logic [15:0] number;
    logic [3:0]  an;
    logic        running, overflow;
    logic [1:0]  state;

    // second instance with a 2-cycle tick so the 99.99 wrap is reachable
    logic btn_start_f = 1'b0, btn_lap_f = 1'b0, btn_clear_f = 1'b0;
    logic [15:0] number_f;
    logic [3:0]  an_f;
    logic        running_f, overflow_f;
    logic [1:0]  state_f;

    stopwatch_controller #(
        .BOARD_CLOCK_FREQUENCY_IN_HZ(F_HZ), .TICK_RATE_IN_HZ(T_HZ), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .number(number), .an(an), .running(running), .overflow(overflow), .state(state)
    );

    stopwatch_controller #(
        .BOARD_CLOCK_FREQUENCY_IN_HZ(200), .TICK_RATE_IN_HZ(100), .DEBOUNCE_CYCLES(DC)
    ) dut_fast (
        .clk(clk), .rst(rst), .btn_start(btn_start_f), .btn_lap(btn_lap_f), .btn_clear(btn_clear_f),
        .number(number_f), .an(an_f), .running(running_f), .overflow(overflow_f), .state(state_f)
    );

    // clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model state (after the most recent posedge)
    int          m_state = 0;
    int          m_run   = 0;
    logic [15:0] m_num   = '0;
    logic        m_ovf   = 1'b0;
    int          ev_clr_at = -1, ev_st_at = -1, ev_lp_at = -1;

    typedef struct {
        logic [2:0] btns;      // {clear, start, lap}
        int         gap;
        int         exp_state;
    } vec_t;
    vec_t vecs[18];

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int next_state(input int s, input bit clr, input bit st, input bit lp);
        if (clr && s == 2) return 0;
        if (st) begin
            if (s == 0 || s == 2) return 1;
            return 2;
        end
        if (lp && s == 1) return 3;
        if (lp && s == 3) return 1;
        return s;
    endfunction

    task automatic model_edge();
        int prev, ns;
        bit clr, st, lp;
        cyc++;
        if (rst) begin
            m_state = 0; m_run = 0; m_num = '0; m_ovf = 1'b0;
            ev_clr_at = -1; ev_st_at = -1; ev_lp_at = -1;
            return;
        end
        clr  = (ev_clr_at == cyc);
        st   = (ev_st_at == cyc);
        lp   = (ev_lp_at == cyc);
        prev = (m_run / DIV_M) % 10000;
        ns   = next_state(m_state, clr, st, lp);
        m_ovf = 1'b0;
        if (m_state == 1 || m_state == 3) begin
            m_run++;
            if (m_run % (DIV_M * 10000) == 0) m_ovf = 1'b1;
        end
        if (m_state == 0 || (m_state == 2 && ns == 0)) m_run = 0;
        if (!(m_state == 3 && ns == 3)) m_num = to_bcd(prev);
        m_state = ns;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic check_model(input string tag);
        logic [3:0] exp_an;
        exp_an = {(m_num[15:12] != 4'd0), 3'b111};
        check({tag, ".state"},    32'(state),    32'(m_state));
        check({tag, ".number"},   32'(number),   32'(m_num));
        check({tag, ".an"},       32'(an),       32'(exp_an));
        check({tag, ".running"},  32'(running),  32'(m_state == 1 || m_state == 3));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".state"},    32'(state),    32'(0));
        check({tag, ".number"},   32'(number),   32'(16'h0000));
        check({tag, ".an"},       32'(an),       32'(4'b0111));
        check({tag, ".running"},  32'(running),  32'(0));
        check({tag, ".overflow"}, 32'(overflow), 32'(0));
    endtask

    // clean press: event reaches the FSM on the 7th edge after the button rises
    task automatic press(input logic [2:0] btns, input int hold);
        btn_clear = btns[2];
        btn_start = btns[1];
        btn_lap   = btns[0];
        if (btns[2]) ev_clr_at = cyc + 7;
        if (btns[1]) ev_st_at  = cyc + 7;
        if (btns[0]) ev_lp_at  = cyc + 7;
        wait_cycles(hold);
        btn_clear = 1'b0;
        btn_start = 1'b0;
        btn_lap   = 1'b0;
    endtask

    initial begin
        int s_fast;
        int guard;
        logic [2:0] mask;

        vecs[0]  = '{3'b100, 15, 1};
        vecs[1]  = '{3'b001, 15, 3};
        vecs[2]  = '{3'b100, 15, 3};
        vecs[3]  = '{3'b001, 20, 1};
        vecs[4]  = '{3'b010, 15, 2};
        vecs[5]  = '{3'b001, 15, 2};
        vecs[6]  = '{3'b010, 25, 1};
        vecs[7]  = '{3'b001, 30, 3};
        vecs[8]  = '{3'b010, 15, 2};
        vecs[9]  = '{3'b110, 15, 0};
        vecs[10] = '{3'b100, 12, 0};
        vecs[11] = '{3'b001, 12, 0};
        vecs[12] = '{3'b010, 40, 1};
        vecs[13] = '{3'b101, 20, 3};
        vecs[14] = '{3'b011, 15, 2};
        vecs[15] = '{3'b010, 35, 1};
        vecs[16] = '{3'b011, 15, 2};
        vecs[17] = '{3'b101, 15, 0};

        // power-on reset, checked asynchronously before any clock edge
        #1 rst = 1'b1;
        #1;
        check_reset_values("por");
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(5);
        check_model("idle");

        // wrap from 99.99 on the fast instance
        btn_start_f = 1'b1;
        s_fast = cyc + 7;
        wait_cycles(10);
        btn_start_f = 1'b0;
        while (cyc < s_fast + 19999) step();
        check("wrap.pre_number",   32'(number_f),   32'(16'h9999));
        check("wrap.pre_an",       32'(an_f),       32'(4'b1111));
        check("wrap.pre_overflow", 32'(overflow_f), 32'(0));
        check("wrap.pre_state",    32'(state_f),    32'(1));
        step();
        check("wrap.overflow",     32'(overflow_f), 32'(1));
        step();
        check("wrap.overflow_off", 32'(overflow_f), 32'(0));
        check("wrap.number",       32'(number_f),   32'(16'h0000));
        check("wrap.an",           32'(an_f),       32'(4'b0111));
        check("wrap.running",      32'(running_f),  32'(1));
        check_model("idle_long");

        // start, then 250 cycles
        press(3'b010, 10);
        wait_cycles(250);
        check("run250.state", 32'(state), 32'(1));
        check("run250.range", 32'(number >= 16'h0024 && number <= 16'h0026), 32'(1));
        check_model("run250");

        // reset mid-RUN with start held through the release
        rst = 1'b1;
        #1;
        check_reset_values("rst_run");
        btn_start = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        ev_st_at = cyc + 7;
        wait_cycles(5);
        check("rst_release.no_event", 32'(state), 32'(0));
        check_model("rst_release");
        wait_cycles(5);
        btn_start = 1'b0;
        check("rst_held.state", 32'(state), 32'(1));
        check_model("rst_held");

        // lap at 00.12, hold for 100 cycles, second lap resumes tracking
        guard = 0;
        while ((m_run / DIV_M) < 12 && guard < 1000) begin
            step();
            guard++;
        end
        press(3'b001, 10);
        check("lap.state",  32'(state),  32'(3));
        check("lap.number", 32'(number), 32'(16'h0012));
        wait_cycles(100);
        check("lap.held",   32'(number), 32'(16'h0012));
        check_model("lap_hold");
        press(3'b001, 10);
        check("lap2.state", 32'(state), 32'(1));
        check_model("lap2");

        // table of button vectors starting from RUN
        for (int i = 0; i < 18; i++) begin
            press(vecs[i].btns, 10);
            wait_cycles(vecs[i].gap);
            check($sformatf("vec%0d.state", i), 32'(state), 32'(vecs[i].exp_state));
            check_model($sformatf("vec%0d", i));
        end

        // pause at 03.45, then clear and start together
        press(3'b010, 10);
        guard = 0;
        while (m_run < 3450 && guard < 5000) begin
            step();
            guard++;
        end
        press(3'b010, 10);
        check("p345.state",  32'(state),  32'(2));
        check("p345.number", 32'(number), 32'(16'h0345));
        press(3'b110, 10);
        check("p345clr.state",  32'(state),  32'(0));
        check("p345clr.number", 32'(number), 32'(16'h0000));
        check_model("p345clr");

        // 2-cycle glitches on start must not register
        for (int g = 0; g < 6; g++) begin
            btn_start = 1'b1;
            wait_cycles(2);
            btn_start = 1'b0;
            wait_cycles(2);
        end
        wait_cycles(12);
        check("glitch.state", 32'(state), 32'(0));
        check_model("glitch");

        // random presses
        for (int r = 0; r < 30; r++) begin
            mask = 3'($urandom_range(1, 7));
            press(mask, $urandom_range(8, 14));
            wait_cycles($urandom_range(10, 40));
            check_model($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
